execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: single-issue RV32-style execute stage.
//   Operand select, ALU/compare, link result, branch/jump redirect, stall
//   and flush handling, one-cycle registered outputs.
//   Optional iterative shift-add multiplier compiled only with macro
//   EXECUTE_MUL_EN; without it the MUL op yields result 0 and no write.
// Ports:
//   c_clk, c_rst            clock, synchronous active-high reset
//   ex_i_ce .. ex_i_pc      decoded instruction (valid, opcode, alu op,
//                           funct3, imm, rs1, rs2, rd, pc)
//   ex_i_stall, ex_i_flush  downstream stall / flush
//   ex_o_result .. ex_o_ce  registered result, store data, rd, write enable,
//                           forwarded opcode/funct3, result valid
//   ex_o_next_pc, ex_o_change_pc, ex_o_flush  registered redirect
//   ex_o_stall              stall to decode (combinational)

package execute_stage_pkg;
  // One-hot opcode classes
  localparam int unsigned OPCODE_WIDTH = 11;
  localparam int unsigned OP_RTYPE  = 0;
  localparam int unsigned OP_ITYPE  = 1;
  localparam int unsigned OP_LOAD   = 2;
  localparam int unsigned OP_STORE  = 3;
  localparam int unsigned OP_BRANCH = 4;
  localparam int unsigned OP_JAL    = 5;
  localparam int unsigned OP_JALR   = 6;
  localparam int unsigned OP_LUI    = 7;
  localparam int unsigned OP_AUIPC  = 8;
  localparam int unsigned OP_SYSTEM = 9;
  localparam int unsigned OP_FENCE  = 10;
  // One-hot ALU operations
  localparam int unsigned ALU_WIDTH = 17;
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_OR   = 5;
  localparam int unsigned ALU_AND  = 6;
  localparam int unsigned ALU_SLL  = 7;
  localparam int unsigned ALU_SRL  = 8;
  localparam int unsigned ALU_SRA  = 9;
  localparam int unsigned ALU_EQ   = 10;
  localparam int unsigned ALU_NEQ  = 11;
  localparam int unsigned ALU_LT   = 12;
  localparam int unsigned ALU_GE   = 13;
  localparam int unsigned ALU_LTU  = 14;
  localparam int unsigned ALU_GEU  = 15;
  localparam int unsigned ALU_MUL  = 16;
endpackage

module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned AWIDTH      = 5,
  parameter int unsigned FUNCT_WIDTH = 3
) (
  input  logic                    c_clk,
  input  logic                    c_rst,
  input  logic                    ex_i_ce,
  input  logic [OPCODE_WIDTH-1:0] ex_i_opcode,
  input  logic [ALU_WIDTH-1:0]    ex_i_alu,
  input  logic [FUNCT_WIDTH-1:0]  ex_i_funct3,
  input  logic [DWIDTH-1:0]       ex_i_imm,
  input  logic [DWIDTH-1:0]       ex_i_rs1,
  input  logic [DWIDTH-1:0]       ex_i_rs2,
  input  logic [AWIDTH-1:0]       ex_i_addr_rd,
  input  logic [PC_WIDTH-1:0]     ex_i_pc,
  input  logic                    ex_i_stall,
  input  logic                    ex_i_flush,
  output logic [DWIDTH-1:0]       ex_o_result,
  output logic [DWIDTH-1:0]       ex_o_rs2,
  output logic [AWIDTH-1:0]       ex_o_addr_rd,
  output logic                    ex_o_we,
  output logic [OPCODE_WIDTH-1:0] ex_o_opcode,
  output logic [FUNCT_WIDTH-1:0]  ex_o_funct3,
  output logic                    ex_o_ce,
  output logic [PC_WIDTH-1:0]     ex_o_next_pc,
  output logic                    ex_o_change_pc,
  output logic                    ex_o_stall,
  output logic                    ex_o_flush
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MUL_BUSY = 2'd2} state_t;
  state_t r_state;

  logic [DWIDTH-1:0]   w_a, w_b, w_alu, w_result;
  logic [4:0]          w_shamt;
  logic                w_lt, w_ltu, w_eq, w_cmp;
  logic                w_is_jump, w_is_mul, w_redirect, w_writes, w_we, w_busy;
  logic [PC_WIDTH-1:0] w_pc_imm, w_jalr_tgt, w_target;

`ifdef EXECUTE_MUL_EN
  localparam int unsigned CNT_W = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  logic [DWIDTH-1:0] r_mul_a, r_mul_b, r_mul_acc, w_mul_sum;
  logic [CNT_W-1:0]  r_mul_cnt;
  logic              r_mul_we;
  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign w_mul_sum = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
`endif

  assign w_busy     = (r_state == MUL_BUSY);
  assign ex_o_stall = ex_i_stall | w_busy;

  // Operand select, ALU, compare, redirect target
  always_comb begin
    w_a = ex_i_rs1;
    if (ex_i_opcode[OP_AUIPC] | ex_i_opcode[OP_JAL] | ex_i_opcode[OP_JALR])
      w_a = DWIDTH'(ex_i_pc);
    else if (ex_i_opcode[OP_LUI])
      w_a = '0;
    w_b     = (ex_i_opcode[OP_RTYPE] | ex_i_opcode[OP_BRANCH]) ? ex_i_rs2 : ex_i_imm;
    w_shamt = w_b[4:0];
    w_lt    = $signed(w_a) < $signed(w_b);
    w_ltu   = w_a < w_b;
    w_eq    = w_a == w_b;

    w_cmp = 1'b0;
    case (1'b1)
      ex_i_alu[ALU_EQ]:  w_cmp = w_eq;
      ex_i_alu[ALU_NEQ]: w_cmp = ~w_eq;
      ex_i_alu[ALU_LT]:  w_cmp = w_lt;
      ex_i_alu[ALU_GE]:  w_cmp = ~w_lt;
      ex_i_alu[ALU_LTU]: w_cmp = w_ltu;
      ex_i_alu[ALU_GEU]: w_cmp = ~w_ltu;
      default:           w_cmp = 1'b0;
    endcase

    w_alu = '0;
    case (1'b1)
      ex_i_alu[ALU_ADD]:  w_alu = w_a + w_b;
      ex_i_alu[ALU_SUB]:  w_alu = w_a - w_b;
      ex_i_alu[ALU_SLT]:  w_alu = DWIDTH'(w_lt);
      ex_i_alu[ALU_SLTU]: w_alu = DWIDTH'(w_ltu);
      ex_i_alu[ALU_XOR]:  w_alu = w_a ^ w_b;
      ex_i_alu[ALU_OR]:   w_alu = w_a | w_b;
      ex_i_alu[ALU_AND]:  w_alu = w_a & w_b;
      ex_i_alu[ALU_SLL]:  w_alu = w_a << w_shamt;
      ex_i_alu[ALU_SRL]:  w_alu = w_a >> w_shamt;
      ex_i_alu[ALU_SRA]:  w_alu = DWIDTH'($signed(w_a) >>> w_shamt);
      ex_i_alu[ALU_EQ], ex_i_alu[ALU_NEQ], ex_i_alu[ALU_LT],
      ex_i_alu[ALU_GE], ex_i_alu[ALU_LTU], ex_i_alu[ALU_GEU]:
                          w_alu = DWIDTH'(w_cmp);
      default:            w_alu = '0;
    endcase

    w_is_jump  = ex_i_opcode[OP_JAL] | ex_i_opcode[OP_JALR];
    w_is_mul   = ex_i_alu[ALU_MUL];
    w_result   = w_is_jump ? DWIDTH'(ex_i_pc + PC_WIDTH'(4)) : w_alu;
    w_pc_imm   = ex_i_pc + PC_WIDTH'(ex_i_imm);
    w_jalr_tgt = PC_WIDTH'(ex_i_rs1 + ex_i_imm) & ~PC_WIDTH'(1);
    w_target   = ex_i_opcode[OP_JALR] ? w_jalr_tgt : w_pc_imm;
    w_redirect = w_is_jump | (ex_i_opcode[OP_BRANCH] & w_cmp);
    w_writes   = (ex_i_opcode[OP_RTYPE] | ex_i_opcode[OP_ITYPE] | ex_i_opcode[OP_LOAD] |
                  ex_i_opcode[OP_LUI] | ex_i_opcode[OP_AUIPC] | w_is_jump) &
                 (ex_i_addr_rd != '0);
    // A MUL never writes on the single-cycle path
    w_we       = w_writes & ~w_is_mul;
  end

  // State machine and output registers; flush beats stall, stall freezes
  // everything except the one-cycle redirect strobes
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      r_state        <= RUN;
      ex_o_result    <= '0;
      ex_o_rs2       <= '0;
      ex_o_addr_rd   <= '0;
      ex_o_we        <= 1'b0;
      ex_o_opcode    <= '0;
      ex_o_funct3    <= '0;
      ex_o_ce        <= 1'b0;
      ex_o_next_pc   <= '0;
      ex_o_change_pc <= 1'b0;
      ex_o_flush     <= 1'b0;
`ifdef EXECUTE_MUL_EN
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_mul_acc      <= '0;
      r_mul_cnt      <= '0;
      r_mul_we       <= 1'b0;
`endif
    end else if (ex_i_flush) begin
      r_state        <= RUN;
      ex_o_ce        <= 1'b0;
      ex_o_we        <= 1'b0;
      ex_o_change_pc <= 1'b0;
      ex_o_flush     <= 1'b0;
    end else if (ex_i_stall) begin
      ex_o_change_pc <= 1'b0;
      ex_o_flush     <= 1'b0;
    end else if (r_state == MUL_BUSY) begin
`ifdef EXECUTE_MUL_EN
      r_mul_acc <= w_mul_sum;
      r_mul_a   <= r_mul_a << 1;
      r_mul_b   <= r_mul_b >> 1;
      r_mul_cnt <= r_mul_cnt + CNT_W'(1);
      if (r_mul_cnt == CNT_W'(DWIDTH - 1)) begin
        ex_o_result <= w_mul_sum;
        ex_o_ce     <= 1'b1;
        ex_o_we     <= r_mul_we;
        r_state     <= RUN;
      end
`else
      r_state <= RUN;
`endif
    end else begin
      ex_o_change_pc <= 1'b0;
      ex_o_flush     <= 1'b0;
      if (!ex_i_ce) begin
        ex_o_ce <= 1'b0;
        ex_o_we <= 1'b0;
      end else if (r_state == FLUSH) begin
        // Instruction fetched down the wrong path: drop it
        ex_o_ce <= 1'b0;
        ex_o_we <= 1'b0;
        r_state <= RUN;
      end else begin
        ex_o_rs2     <= ex_i_rs2;
        ex_o_addr_rd <= ex_i_addr_rd;
        ex_o_opcode  <= ex_i_opcode;
        ex_o_funct3  <= ex_i_funct3;
        ex_o_next_pc <= w_target;
`ifdef EXECUTE_MUL_EN
        if (w_is_mul) begin
          ex_o_ce   <= 1'b0;
          ex_o_we   <= 1'b0;
          r_mul_a   <= w_a;
          r_mul_b   <= w_b;
          r_mul_acc <= '0;
          r_mul_cnt <= '0;
          r_mul_we  <= w_writes;
          r_state   <= MUL_BUSY;
        end else
`endif
        begin
          ex_o_ce        <= 1'b1;
          ex_o_we        <= w_we;
          ex_o_result    <= w_result;
          ex_o_change_pc <= w_redirect;
          ex_o_flush     <= w_redirect;
          r_state        <= w_redirect ? FLUSH : RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus a random
// instruction stream, compared against an arithmetic reference model.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        c_clk, c_rst;
  logic        i_ce, i_stall, i_flush;
  logic [OPCODE_WIDTH-1:0] i_opcode;
  logic [ALU_WIDTH-1:0]    i_alu;
  logic [2:0]  i_f3;
  logic [31:0] i_imm, i_rs1, i_rs2, i_pc;
  logic [4:0]  i_rd;
  int unsigned cur_opc, cur_alu;

  logic [31:0] o_result, o_rs2, o_next_pc;
  logic [4:0]  o_rd;
  logic        o_we, o_ce, o_change_pc, o_stall, o_flush;
  logic [OPCODE_WIDTH-1:0] o_opcode;
  logic [2:0]  o_f3;

  // Expected output state
  logic [31:0] e_result, e_rs2, e_npc;
  logic [4:0]  e_rd;
  logic [OPCODE_WIDTH-1:0] e_opc;
  logic [2:0]  e_f3;
  logic        e_ce, e_we, e_cpc, e_fl, squash;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .c_clk(c_clk), .c_rst(c_rst),
    .ex_i_ce(i_ce), .ex_i_opcode(i_opcode), .ex_i_alu(i_alu), .ex_i_funct3(i_f3),
    .ex_i_imm(i_imm), .ex_i_rs1(i_rs1), .ex_i_rs2(i_rs2), .ex_i_addr_rd(i_rd),
    .ex_i_pc(i_pc), .ex_i_stall(i_stall), .ex_i_flush(i_flush),
    .ex_o_result(o_result), .ex_o_rs2(o_rs2), .ex_o_addr_rd(o_rd), .ex_o_we(o_we),
    .ex_o_opcode(o_opcode), .ex_o_funct3(o_f3), .ex_o_ce(o_ce),
    .ex_o_next_pc(o_next_pc), .ex_o_change_pc(o_change_pc),
    .ex_o_stall(o_stall), .ex_o_flush(o_flush)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: instruction semantics from plain arithmetic
  function automatic void model(input int unsigned opc, input int unsigned alu,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [4:0] rd, output logic [31:0] res,
                                output logic we, output logic redir,
                                output logic [31:0] tgt);
    logic [31:0] a, b, p2, sa, sb;
    logic        writer;
    a = rs1;
    if (opc == OP_AUIPC || opc == OP_JAL || opc == OP_JALR) a = pc;
    else if (opc == OP_LUI) a = 32'd0;
    b  = (opc == OP_RTYPE || opc == OP_BRANCH) ? rs2 : imm;
    p2 = 32'd1 << 32'(b[4:0]);
    sa = a ^ 32'h8000_0000;   // offset binary: unsigned order == signed order
    sb = b ^ 32'h8000_0000;
    case (alu)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  res = a ^ b;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      ALU_SLL:  res = a * p2;
      ALU_SRL:  res = a / p2;
      ALU_SRA:  res = a[31] ? ~((~a) / p2) : a / p2;
      ALU_EQ:   res = (a == b) ? 32'd1 : 32'd0;
      ALU_NEQ:  res = (a != b) ? 32'd1 : 32'd0;
      ALU_LT:   res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_GE:   res = (sa >= sb) ? 32'd1 : 32'd0;
      ALU_LTU:  res = (a < b) ? 32'd1 : 32'd0;
      ALU_GEU:  res = (a >= b) ? 32'd1 : 32'd0;
      default:  res = 32'd0;
    endcase
    redir = (opc == OP_JAL) || (opc == OP_JALR) || (opc == OP_BRANCH && res == 32'd1);
    if (opc == OP_JAL || opc == OP_JALR) res = pc + 32'd4;
    tgt = (opc == OP_JALR) ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
    writer = (opc == OP_RTYPE) || (opc == OP_ITYPE) || (opc == OP_LOAD) || (opc == OP_LUI) ||
             (opc == OP_AUIPC) || (opc == OP_JAL) || (opc == OP_JALR);
    we = writer && (rd != 5'd0) && (alu != ALU_MUL);
  endfunction

  task automatic drive(input logic ce, input int unsigned opc, input int unsigned alu,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    i_ce = ce; cur_opc = opc; cur_alu = alu;
    i_opcode = OPCODE_WIDTH'(1) << opc;
    i_alu    = ALU_WIDTH'(1) << alu;
    i_f3 = 3'($urandom); i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_pc = pc; i_rd = rd;
    i_stall = 1'b0; i_flush = 1'b0;
  endtask

  // One clock: advance the expected state, then compare every output
  task automatic step();
    logic [31:0] r, t;
    logic        w, rd_;
    @(posedge c_clk);
    if (c_rst) begin
      e_result = '0; e_rs2 = '0; e_npc = '0; e_rd = '0; e_opc = '0; e_f3 = '0;
      e_ce = 0; e_we = 0; e_cpc = 0; e_fl = 0; squash = 0;
    end else if (i_flush) begin
      e_ce = 0; e_we = 0; e_cpc = 0; e_fl = 0; squash = 0;
    end else if (i_stall) begin
      e_cpc = 0; e_fl = 0;
    end else begin
      e_cpc = 0; e_fl = 0;
      if (!i_ce) begin
        e_ce = 0; e_we = 0;
      end else if (squash) begin
        e_ce = 0; e_we = 0; squash = 0;
      end else begin
        model(cur_opc, cur_alu, i_rs1, i_rs2, i_imm, i_pc, i_rd, r, w, rd_, t);
        e_ce = 1; e_we = w; e_result = r; e_rs2 = i_rs2; e_rd = i_rd;
        e_opc = i_opcode; e_f3 = i_f3;
        if (rd_) begin e_cpc = 1; e_fl = 1; e_npc = t; squash = 1; end
      end
    end
    #1;
    check("ce", 32'(o_ce), 32'(e_ce));
    check("we", 32'(o_we), 32'(e_we));
    check("result", o_result, e_result);
    check("rs2", o_rs2, e_rs2);
    check("rd", 32'(o_rd), 32'(e_rd));
    check("opcode", 32'(o_opcode), 32'(e_opc));
    check("funct3", 32'(o_f3), 32'(e_f3));
    check("change_pc", 32'(o_change_pc), 32'(e_cpc));
    check("flush_out", 32'(o_flush), 32'(e_fl));
    check("stall_out", 32'(o_stall), 32'(i_stall));
    if (e_cpc) check("next_pc", o_next_pc, e_npc);
  endtask

  initial begin
    int unsigned opc, alu;
    logic [31:0] rs1;
    int n;

    // Reset
    c_rst = 1'b1;
    drive(0, OP_RTYPE, ALU_ADD, 0, 0, 0, 0, 0);
    step();
    check("rst_next_pc", o_next_pc, 32'd0);
    c_rst = 1'b0;

    // ADD 5+7
    drive(1, OP_RTYPE, ALU_ADD, 5, 7, 0, 32'h4, 3); step();
    check("add_12", o_result, 32'd12);
    check("add_we", 32'(o_we), 32'd1);
    // SRA by immediate, SLTU, signed SLT
    drive(1, OP_ITYPE, ALU_SRA, 32'h8000_0000, 0, 4, 32'h8, 4); step();
    check("sra", o_result, 32'hF800_0000);
    drive(1, OP_RTYPE, ALU_SLTU, 1, 32'hFFFF_FFFF, 0, 32'hC, 5); step();
    check("sltu", o_result, 32'd1);
    drive(1, OP_RTYPE, ALU_SLT, 32'hFFFF_FFFF, 1, 0, 32'hC, 5); step();
    check("slt_neg", o_result, 32'd1);
    // rd = 0 never writes; LUI passes the immediate
    drive(1, OP_ITYPE, ALU_ADD, 5, 0, 1, 0, 0); step();
    check("rd0_we", 32'(o_we), 32'd0);
    drive(1, OP_LUI, ALU_ADD, 32'hDEAD, 0, 32'h1234_5000, 0, 7); step();
    check("lui", o_result, 32'h1234_5000);

    // Taken branch, then wrong-path instruction discarded
    drive(1, OP_BRANCH, ALU_EQ, 3, 3, 8, 32'h10, 0); step();
    check("br_cpc", 32'(o_change_pc), 32'd1);
    check("br_target", o_next_pc, 32'h18);
    drive(1, OP_RTYPE, ALU_ADD, 1, 2, 0, 32'h14, 6); step();
    check("br_discard", 32'(o_ce), 32'd0);
    check("br_pulse_end", 32'(o_change_pc), 32'd0);
    drive(1, OP_RTYPE, ALU_ADD, 1, 2, 0, 32'h18, 6); step();
    check("br_resume", o_result, 32'd3);

    // JALR with odd target, then 3 stalled cycles
    drive(1, OP_JALR, ALU_ADD, 32'h101, 0, 2, 32'h20, 1); step();
    check("jalr_target", o_next_pc, 32'h102);
    check("jalr_link", o_result, 32'h24);
    drive(1, OP_RTYPE, ALU_ADD, 9, 9, 0, 32'h24, 2);
    i_stall = 1'b1;
    repeat (3) begin
      step();
      check("stall_result", o_result, 32'h24);
      check("stall_ce", 32'(o_ce), 32'd1);
    end
    i_stall = 1'b0; step();
    check("jalr_discard", 32'(o_ce), 32'd0);

    // Flush with valid input; flush dominating stall and redirect
    drive(1, OP_RTYPE, ALU_ADD, 1, 1, 0, 0, 3); i_flush = 1'b1; step();
    check("flush_ce", 32'(o_ce), 32'd0);
    drive(1, OP_JAL, ALU_ADD, 0, 0, 32'h40, 32'h30, 1); i_flush = 1'b1; i_stall = 1'b1; step();
    check("flush_dom_cpc", 32'(o_change_pc), 32'd0);
    drive(1, OP_RTYPE, ALU_SUB, 10, 3, 0, 32'h34, 3); step();
    check("after_flush", o_result, 32'd7);

`ifdef EXECUTE_MUL_EN
    // 6 x 7 through the iterative multiplier
    drive(1, OP_RTYPE, ALU_MUL, 6, 7, 0, 0, 4);
    @(posedge c_clk); #1;
    i_ce = 1'b0;
    n = 0;
    while (o_stall === 1'b1 && n < 100) begin @(posedge c_clk); #1; n++; end
    check("mul_busy_cycles", 32'(n), 32'd32);
    check("mul_result", o_result, 32'd42);
    check("mul_ce", 32'(o_ce), 32'd1);
    check("mul_we", 32'(o_we), 32'd1);
    e_result = 32'd42; e_rs2 = 32'd7; e_rd = 5'd4; e_ce = 1; e_we = 1;
    e_opc = OPCODE_WIDTH'(1) << OP_RTYPE; e_f3 = i_f3; e_cpc = 0; e_fl = 0; squash = 0;
    // Reset in the middle of a multiply
    drive(1, OP_RTYPE, ALU_MUL, 3, 5, 0, 0, 4);
    @(posedge c_clk); #1;
    i_ce = 1'b0;
    repeat (5) @(posedge c_clk);
    #1;
    c_rst = 1'b1; step();
    check("mul_rst_npc", o_next_pc, 32'd0);
    c_rst = 1'b0;
`else
    drive(1, OP_RTYPE, ALU_MUL, 6, 7, 0, 0, 4); step();
    check("mul_off_result", o_result, 32'd0);
    check("mul_off_we", 32'(o_we), 32'd0);
`endif

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      opc = $urandom_range(OP_AUIPC, OP_RTYPE);
      if (opc == OP_BRANCH) alu = $urandom_range(ALU_GEU, ALU_EQ);
      else                  alu = $urandom_range(ALU_SRA, ALU_ADD);
`ifndef EXECUTE_MUL_EN
      if (opc == OP_RTYPE && $urandom_range(7, 0) == 0) alu = ALU_MUL;
`endif
      rs1 = ($urandom_range(3, 0) == 0) ? $urandom_range(15, 0) : $urandom;
      drive($urandom_range(4, 0) != 0, opc, alu, rs1,
            ($urandom_range(3, 0) == 0) ? rs1 : $urandom, $urandom,
            $urandom & 32'hFFFF_FFFC, 5'($urandom));
      i_stall = ($urandom_range(5, 0) == 0);
      i_flush = ($urandom_range(15, 0) == 0);
      step();
    end

    // Reset mid-stream
    drive(1, OP_RTYPE, ALU_ADD, 1, 2, 0, 0, 9); step();
    c_rst = 1'b1;
    drive(1, OP_JAL, ALU_ADD, 0, 0, 8, 32'h50, 9); step();
    check("rst_mid_npc", o_next_pc, 32'd0);
    check("rst_mid_result", o_result, 32'd0);
    c_rst = 1'b0;
    drive(0, OP_RTYPE, ALU_ADD, 0, 0, 0, 0, 0); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
